// File: rtl/offset_calib.sv
// DC offset calibration: averages 2^LOG2_N valid samples and produces the
// registered negated mean as a correction, optionally re-arming every window.
module offset_calib #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [DATA_WIDTH-1:0] data_i_tdata,
  input  logic                  data_i_tvalid,
  output logic [DATA_WIDTH-1:0] offset,
  output logic                  offset_valid,
  output logic                  busy
);

  localparam int ACC_W = DATA_WIDTH + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0]      LAST  = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_V = ~MIN_V;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] sample_ext;
  logic [DATA_WIDTH-1:0]   mean, corr;
  logic                    clr, take;

  assign sample_ext = {{LOG2_N{data_i_tdata[DATA_WIDTH-1]}}, data_i_tdata};

  // Arithmetic shift gives floor rounding; the result always fits DATA_WIDTH.
  assign mean = DATA_WIDTH'(acc >>> LOG2_N);
  assign corr = (mean == MIN_V) ? MAX_V : DATA_WIDTH'(-mean);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (data_i_tvalid) begin
          take = 1'b1;
          if (cnt == LAST) state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        // Clearing here is harmless when returning to IDLE, required when re-arming.
        clr       = 1'b1;
        state_nxt = continuous ? ACCUM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      offset       <= '0;
      offset_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != IDLE);
      offset_valid <= (state == OUTPUT);
      if (state == OUTPUT) offset <= corr;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        acc <= acc + sample_ext;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_offset_calib.sv
// Scoreboard bench for offset_calib (N=4): window-level driver pushes expected
// corrections; a negedge monitor pops and checks value and arrival cycle.
module tb_offset_calib;
  localparam int DW = 16;
  localparam int L2 = 2;
  localparam int N  = 4;

  typedef struct {
    logic [DW-1:0] off;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, continuous, data_i_tvalid;
  logic [DW-1:0] data_i_tdata;
  logic [DW-1:0] offset;
  logic          offset_valid, busy;

  exp_t                 sb[$];
  int                   cyc = 0;
  int                   vectors = 0;
  int                   miscompares = 0;
  logic [DW-1:0]        last_off = '0;
  logic signed [DW-1:0] wv[N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  offset_calib #(.DATA_WIDTH(DW), .LOG2_N(L2)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .data_i_tdata(data_i_tdata), .data_i_tvalid(data_i_tvalid),
    .offset(offset), .offset_valid(offset_valid), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: floor of the window mean, negated, with the one saturating case.
  function automatic logic [DW-1:0] ref_off(input int s);
    int m;
    m = s / N;
    if ((s % N != 0) && (s < 0)) m = m - 1;
    if (m == -32768) return 16'h7fff;
    return DW'(-m);
  endfunction

  always @(negedge clk) begin
    if (offset_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("offset", offset, e.off);
        chk("latency", cyc, e.due);
        last_off = e.off;
      end
    end
  end

  task automatic drive(input logic s, input logic v, input logic [DW-1:0] d);
    start         = s;
    data_i_tvalid = v;
    data_i_tdata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rst(input int n);
    reset    = 1'b1;
    last_off = '0;
    for (int i = 0; i < n; i++) begin
      continuous = 1'($urandom);
      drive(1'($urandom), 1'($urandom), 16'($urandom));
      chk("rst_offset", offset, 0);
      chk("rst_valid", offset_valid, 0);
      chk("rst_busy", busy, 0);
    end
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'($urandom), 16'($urandom));
      chk("idle_busy", busy, 0);
      chk("hold_offset", offset, last_off);
    end
  endtask

  // One measurement window over wv[]; gap cycles carry tvalid=0, and the
  // OUTPUT cycle carries a junk valid sample that must be discarded.
  task automatic do_window(input bit with_start, input int mingap, input int maxgap,
                           input bit cont, input bit busy_start);
    int sum = 0;
    int k   = 0;
    int gaps;
    continuous = cont;
    if (with_start) begin
      drive(1'b1, 1'($urandom), 16'($urandom));
      chk("busy_after_start", busy, 1);
    end
    for (int i = 0; i < N; i++) begin
      gaps = int'($urandom_range(maxgap, mingap));
      for (int g = 0; g < gaps; g++) begin
        drive(busy_start && ($urandom % 2 == 1), 1'b0, 16'($urandom));
        chk("busy_in_gap", busy, 1);
      end
      k = cyc;
      drive(busy_start && (i == 1), 1'b1, wv[i]);
      chk("busy_in_window", busy, 1);
      sum += int'(wv[i]);
    end
    sb.push_back('{off: ref_off(sum), due: k + 2});
    drive(busy_start, 1'b1, 16'($urandom));
    chk("busy_after_output", busy, {31'd0, cont});
  endtask

  initial begin
    bit prev_cont;
    bit cont;
    reset = 1'b1; start = 1'b0; continuous = 1'b0;
    data_i_tvalid = 1'b0; data_i_tdata = '0;

    rst(3);
    idle(2);

    foreach (wv[i]) wv[i] = 16'sd100;
    do_window(1, 0, 0, 0, 0);
    idle(2);

    wv[0] = 16'sd10; wv[1] = 16'sd20; wv[2] = 16'sd30; wv[3] = 16'sd40;
    do_window(1, 1, 3, 0, 1);
    idle(3);

    wv[0] = -16'sd1; wv[1] = 16'sd0; wv[2] = 16'sd0; wv[3] = 16'sd0;
    do_window(1, 0, 1, 0, 0);
    idle(1);
    foreach (wv[i]) wv[i] = 16'sh8000;
    do_window(1, 0, 1, 0, 0);
    idle(2);

    foreach (wv[i]) wv[i] = 16'sd8;
    do_window(1, 0, 0, 1, 0);
    do_window(0, 0, 0, 1, 0);
    do_window(0, 0, 0, 0, 0);
    idle(2);

    continuous = 1'b0;
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 16'sd50);
    drive(1'b0, 1'b1, 16'sd50);
    rst(2);
    foreach (wv[i]) wv[i] = 16'sd4;
    do_window(1, 0, 1, 0, 0);
    idle(2);

    prev_cont = 1'b0;
    for (int w = 0; w < 20; w++) begin
      foreach (wv[i]) wv[i] = 16'($urandom);
      cont = (w < 19) ? 1'($urandom) : 1'b0;
      do_window(!prev_cont, 0, 3, cont, 1'($urandom));
      if (!cont) idle(int'($urandom_range(3, 1)));
      prev_cont = cont;
    end

    idle(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
